// File: rtl/mult_final_adder.sv
// mult_final_adder: final carry-propagate stage of the 16x16 radix-4 Booth
// multiplier. Resolves the redundant carry/sum vectors from dadda_tree into the
// two's-complement product with a chunked ripple adder, CHUNK bits per cycle.
// WIDTH must be a multiple of CHUNK.
module mult_final_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [CHUNK:0]   chunk_sum;
  int               base;
  logic             accept;
  logic             last_chunk;

  // in_ready is forced low while reset is asserted, not just after the state clears.
  assign in_ready   = (state == IDLE) && !rst;
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign accept     = in_valid && in_ready;
  assign last_chunk = (idx_q == LAST_IDX);

  // Ripple-add the current chunk pair plus the carry from the previous chunk.
  assign base      = int'(idx_q) * CHUNK;
  assign chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_q};

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, walk the chunks in ADD, hold in DONE.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (last_chunk) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, chunk index, carry and product accumulation.
  // NOTE: the operand registers are plain flops, not a memory, so they are
  // reset along with everything else; an abort leaves no stale operands behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= 1'b0;
            idx_q   <= '0;
            product <= '0;
          end
        end
        ADD: begin
          product[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
          if (last_chunk) begin
            // Carry out of the top bit is discarded: the add is modulo 2^WIDTH.
            carry_q <= 1'b0;
            idx_q   <= '0;
          end else begin
            carry_q <= chunk_sum[CHUNK];
            idx_q   <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_final_adder.sv
// Directed bench for mult_final_adder: reset, carry chain, wrap, back-pressure,
// Booth-style vectors, reset during an add, and back-to-back transfers.
module tb_mult_final_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mult_final_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait until the block is ready; bounded.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: in_ready=%b want 1 after %0d cycles", name, in_ready, n);
    end
  endtask

  // One full transaction: accept, count latency, check product, drain.
  task automatic run_pair(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
    int n;
    wait_ready(name);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL %s_latency: got %0d cycles want 4", name, n);
    end
    total++;
    if (product !== exp) begin
      bad++;
      $display("FAIL %s_product: got %h want %h", name, product, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || product !== exp) begin
      bad++;
      $display("FAIL %s_drain: out_valid=%b product=%h want 0 %h", name, out_valid, product, exp);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    repeat (3) tick();
    total++;
    if ({in_ready, out_valid, busy} !== 3'b000 || product !== 32'h0) begin
      bad++;
      $display("FAIL reset_held: rdy/vld/busy=%b product=%h want 000 0",
               {in_ready, out_valid, busy}, product);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100 || product !== 32'h0) begin
      bad++;
      $display("FAIL reset_release: rdy/vld/busy=%b product=%h want 100 0",
               {in_ready, out_valid, busy}, product);
    end
  endtask

  task automatic test_cross_chunk();
    run_pair(32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, "cross_chunk");
    run_pair(32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, "carry_3chunk");
  endtask

  task automatic test_wrap();
    run_pair(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "wrap_ones");
    run_pair(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "wrap_msb");
  endtask

  task automatic test_back_pressure();
    int n;
    wait_ready("bp");
    in_valid = 1'b1;
    in_a     = 32'h00FF_00FF;
    in_b     = 32'h0001_0001;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    // New data offered while the result is held.
    in_valid = 1'b1;
    in_a     = 32'h1111_2222;
    in_b     = 32'h0000_1111;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (product !== 32'h0100_0100 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold[%0d]: product=%h rdy=%b vld=%b want 01000100 0 1",
                 i, product, in_ready, out_valid);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001 || product !== 32'h0100_0100) begin
      bad++;
      $display("FAIL bp_release: vld/busy/rdy=%b product=%h want 001 01000100",
               {out_valid, busy, in_ready}, product);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL bp_accept_next: busy=%b want 1", busy);
    end
    repeat (4) tick();
    total++;
    if (out_valid !== 1'b1 || product !== 32'h1111_3333) begin
      bad++;
      $display("FAIL bp_second: vld=%b product=%h want 1 11113333", out_valid, product);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_booth_vectors();
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic [31:0] p;
    logic [31:0] a;
    // -32768 * 32767 split into redundant pairs with and without internal carries.
    run_pair(32'hC000_0000, 32'h0000_8000, 32'hC000_8000, "booth_min_max");
    run_pair(32'hBFFF_FFFF, 32'h0000_8001, 32'hC000_8000, "booth_min_max_c");
    // -1 * -1
    run_pair(32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, "booth_m1_m1");
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      p = 32'(int'(x) * int'(y));
      a = $urandom;
      run_pair(a, p - a, p, "booth_rand");
    end
  endtask

  task automatic test_reset_mid_add();
    wait_ready("rst_mid");
    in_valid = 1'b1;
    in_a     = 32'h1212_1212;
    in_b     = 32'h0101_0101;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    total++;
    if (busy !== 1'b1 || product !== 32'h0000_1313) begin
      bad++;
      $display("FAIL rst_mid_partial: busy=%b product=%h want 1 00001313", busy, product);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, busy, in_ready} !== 3'b000 || product !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_abort: vld/busy/rdy=%b product=%h want 000 0",
               {out_valid, busy, in_ready}, product);
    end
    tick();
    rst = 1'b0;
    #1;
    run_pair(32'h1234_5678, 32'h1111_1111, 32'h2345_6789, "rst_mid_after");
  endtask

  task automatic test_back_to_back();
    int n;
    wait_ready("b2b");
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'h0000_0001;
    in_b      = 32'h0000_0002;
    tick();
    // Changing the inputs mid-add must not disturb the latched pair.
    in_a = 32'h7FFF_FFFF;
    in_b = 32'h0000_0001;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (product !== 32'h0000_0003) begin
      bad++;
      $display("FAIL b2b_first: product=%h want 00000003", product);
    end
    tick();
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_no_overlap: vld/busy=%b want 00", {out_valid, busy});
    end
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b want 1", busy);
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n !== 4 || product !== 32'h8000_0000) begin
      bad++;
      $display("FAIL b2b_second: latency=%0d product=%h want 4 80000000", n, product);
    end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cross_chunk();
    test_wrap();
    test_back_pressure();
    test_booth_vectors();
    test_reset_mid_add();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
